mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports if_req, input, 1, fetch request; if_addr, input, AW, fetch address (driven by program_counter).
REQ-007 SHALL have port if_flush, input, 1, discard fetch (branch taken).
REQ-008 SHALL have ports if_gnt, output, 1, fetch granted; if_rvalid, output, 1, fetch data valid; if_rdata, output, DW, instruction word.
REQ-009 SHALL have ports d_req, d_we, input, 1 each, data request / write; d_addr, input, AW; d_wdata, input, DW.
REQ-010 SHALL have ports d_gnt, output, 1; d_rvalid, output, 1, load data valid; d_rdata, output, DW.
REQ-011 SHALL have ports mem_en, mem_we, output, 1 each; mem_addr, output, AW; mem_wdata, output, DW; mem_rdata, input, DW; this is a single-port synchronous memory.
REQ-012 SHALL have port busy, output, 1, read outstanding.

Function
REQ-013 SHALL share one memory port between fetch and data requesters, with at most one read outstanding.
REQ-014 SHALL implement FSM IDLE/BUSY: a read grant moves to BUSY and loads a counter with MEM_LAT-1; a write grant stays in or returns to IDLE.
REQ-015 SHALL, in BUSY, decrement the counter each cycle; the cycle the counter is 0 is the response cycle; next state is IDLE unless a new read is granted that cycle.
REQ-016 SHALL permit a grant combinationally in IDLE or in the response cycle, and in no other cycle.
REQ-017 SHALL, for a read granted in cycle T, assert the owner's rvalid for exactly one cycle at T+MEM_LAT, with rdata = mem_rdata in that cycle.
REQ-018 SHALL complete a write in its grant cycle, with no rvalid.
REQ-019 SHALL drive mem_en = if_gnt | d_gnt, mem_we = d_gnt & d_we, and mem_addr/mem_wdata from the granted requester; unused fields are 0.
REQ-020 SHALL treat a request as held until its gnt; gnt is a one-cycle pulse per transaction; if_gnt and d_gnt are never asserted together.
REQ-021 SHALL resolve simultaneous if_req and d_req per REQ-029.
REQ-022 SHALL, when if_flush is high, mask if_req that cycle (no fetch grant).
REQ-023 SHALL suppress if_rvalid in the response cycle when if_flush is high in any cycle from grant+1 through the response cycle; busy timing is unchanged.
REQ-024 SHALL assert busy when state is BUSY.
REQ-025 SHALL drive if_rdata and d_rdata = mem_rdata continuously; they are valid only with rvalid.

Reset
REQ-026 SHALL, on rst assertion, immediately force state IDLE, counter 0, and the round-robin pointer to "data"; all outputs are 0 while rst is high.
REQ-027 SHALL, on reset mid-transaction, drop the outstanding read with no rvalid afterward.
REQ-028 SHALL allow a grant in the first clock edge cycle after rst deasserts.

Configuration
REQ-029 SHALL, with ARB_ROUND_ROBIN_EN defined, on a conflict grant the requester not granted at the last conflict, starting with data after reset; without the macro, data always wins a conflict (fixed priority).

Verification
REQ-030 SHALL cover: MEM_LAT=1, fetch-only if_req at addr 0x0 -> if_gnt cycle T, if_rvalid cycle T+1, if_rdata=mem_rdata.
REQ-031 SHALL cover: MEM_LAT=3, load at 0x100 then fetch held high -> d_rvalid at T+3, if_gnt in the same cycle T+3, no grant at T+1 or T+2.
REQ-032 SHALL cover: store 0xDEADBEEF to 0x40 -> mem_we=1, mem_wdata=0xDEADBEEF at grant; next grant allowed at T+1; no d_rvalid.
REQ-033 SHALL cover: both requesting continuously for 6 grants -> fixed build gives d,d,d,d,d,d; ARB_ROUND_ROBIN_EN build gives d,i,d,i,d,i.
REQ-034 SHALL cover: MEM_LAT=2, fetch granted at T, if_flush pulse at T+1 -> no if_rvalid at T+2, busy low at T+3.
REQ-035 SHALL cover: rst pulse at T+1 during an outstanding MEM_LAT=4 read -> all outputs 0 immediately, no rvalid thereafter.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for alternating conflict priority; otherwise data always wins a conflict.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       owner_q, owner_d;   // 1 = data requester owns the outstanding read
   logic       flush_q, flush_d;   // fetch was flushed while its read was in flight

   logic resp;
   logic can_grant;
   logic fetch_req;
   logic conflict;
   logic prefer_data;
   logic if_gnt_c;
   logic d_gnt_c;
   logic read_gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         owner_q <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         flush_q <= flush_d;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_q, rr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= 1'b1;
      else     rr_q <= rr_d;
   end

   // Whoever wins a conflict yields the next one.
   always_comb begin
      rr_d = rr_q;
      if (conflict && can_grant) rr_d = ~d_gnt_c;
   end

   assign prefer_data = rr_q;
`else
   assign prefer_data = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      flush_d  = flush_q | ((state_q == BUSY) & if_flush);
      read_gnt = if_gnt_c | (d_gnt_c & ~d_we);
      if (read_gnt) begin
         state_d = BUSY;
         cnt_d   = CNT_INIT;
         owner_d = d_gnt_c;
         flush_d = 1'b0;
      end else if (state_q == BUSY) begin
         if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
         else               state_d = IDLE;
      end
   end

   always_comb begin
      resp      = (state_q == BUSY) && (cnt_q == 2'd0);
      can_grant = ~rst & ((state_q == IDLE) | resp);
      fetch_req = if_req & ~if_flush;
      conflict  = fetch_req & d_req;
      d_gnt_c   = can_grant & d_req & (~fetch_req | prefer_data);
      if_gnt_c  = can_grant & fetch_req & ~d_gnt_c;

      if_gnt    = if_gnt_c;
      d_gnt     = d_gnt_c;
      mem_en    = if_gnt_c | d_gnt_c;
      mem_we    = d_gnt_c & d_we;
      mem_addr  = if_gnt_c ? if_addr : (d_gnt_c ? d_addr : '0);
      mem_wdata = (d_gnt_c & d_we) ? d_wdata : '0;
      // A flush in the response cycle itself also kills the fetch data.
      if_rvalid = ~rst & resp & ~owner_q & ~flush_q & ~if_flush;
      d_rvalid  = ~rst & resp & owner_q;
      if_rdata  = rst ? '0 : mem_rdata;
      d_rdata   = rst ? '0 : mem_rdata;
      busy      = ~rst & (state_q == BUSY);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four instances (MEM_LAT 1..4) share one stimulus stream.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_flush, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;

   logic        if_gnt_w    [1:4];
   logic        if_rvalid_w [1:4];
   logic [31:0] if_rdata_w  [1:4];
   logic        d_gnt_w     [1:4];
   logic        d_rvalid_w  [1:4];
   logic [31:0] d_rdata_w   [1:4];
   logic        mem_en_w    [1:4];
   logic        mem_we_w    [1:4];
   logic [31:0] mem_addr_w  [1:4];
   logic [31:0] mem_wdata_w [1:4];
   logic        busy_w      [1:4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 1; gi <= 4; gi++) begin : g_dut
         mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(gi)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
            .if_gnt(if_gnt_w[gi]), .if_rvalid(if_rvalid_w[gi]), .if_rdata(if_rdata_w[gi]),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_gnt(d_gnt_w[gi]), .d_rvalid(d_rvalid_w[gi]), .d_rdata(d_rdata_w[gi]),
            .mem_en(mem_en_w[gi]), .mem_we(mem_we_w[gi]), .mem_addr(mem_addr_w[gi]),
            .mem_wdata(mem_wdata_w[gi]), .mem_rdata(mem_rdata), .busy(busy_w[gi])
         );
      end
   endgenerate

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", name, got);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
      repeat (n) next_cycle();
   endtask

   task automatic test_reset();
      d_req = 1; d_addr = 32'h10; mem_rdata = 32'hA5A5_A5A5;
      @(negedge clk);
      chk("reset d_gnt", {31'd0, d_gnt_w[1]}, 32'd0);
      chk("reset mem_en", {31'd0, mem_en_w[1]}, 32'd0);
      chk("reset busy", {31'd0, busy_w[1]}, 32'd0);
      chk("reset d_rdata", d_rdata_w[1], 32'd0);
      chk("reset mem_addr", mem_addr_w[1], 32'd0);
      next_cycle();
      rst = 0;
      @(negedge clk);
      chk("first-cycle d_gnt", {31'd0, d_gnt_w[1]}, 32'd1);
      chk("first-cycle mem_addr", mem_addr_w[1], 32'h10);
      next_cycle();
      d_req = 0;
      @(negedge clk);
      chk("first-cycle d_rvalid", {31'd0, d_rvalid_w[1]}, 32'd1);
      chk("first-cycle d_rdata", d_rdata_w[1], 32'hA5A5_A5A5);
      idle(5);
   endtask

   task automatic test_fetch();
      if_req = 1; if_addr = 32'h0; mem_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("fetch if_gnt T", {31'd0, if_gnt_w[1]}, 32'd1);
      chk("fetch mem_addr T", mem_addr_w[1], 32'h0);
      chk("fetch mem_we T", {31'd0, mem_we_w[1]}, 32'd0);
      next_cycle();
      if_req = 0;
      @(negedge clk);
      chk("fetch if_rvalid T+1", {31'd0, if_rvalid_w[1]}, 32'd1);
      chk("fetch if_rdata T+1", if_rdata_w[1], 32'h1234_5678);
      chk("fetch busy T+1", {31'd0, busy_w[1]}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("fetch if_rvalid T+2", {31'd0, if_rvalid_w[1]}, 32'd0);
      chk("fetch busy T+2", {31'd0, busy_w[1]}, 32'd0);
      idle(5);
   endtask

   task automatic test_load_then_fetch();
      d_req = 1; d_we = 0; d_addr = 32'h100; mem_rdata = 32'hCAFE_0001;
      @(negedge clk);
      chk("lat3 d_gnt T", {31'd0, d_gnt_w[3]}, 32'd1);
      chk("lat3 mem_addr T", mem_addr_w[3], 32'h100);
      next_cycle();
      d_req = 0; if_req = 1; if_addr = 32'h200;
      @(negedge clk);
      chk("lat3 if_gnt T+1", {31'd0, if_gnt_w[3]}, 32'd0);
      chk("lat3 busy T+1", {31'd0, busy_w[3]}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("lat3 if_gnt T+2", {31'd0, if_gnt_w[3]}, 32'd0);
      chk("lat3 d_rvalid T+2", {31'd0, d_rvalid_w[3]}, 32'd0);
      next_cycle();
      @(negedge clk);
      chk("lat3 d_rvalid T+3", {31'd0, d_rvalid_w[3]}, 32'd1);
      chk("lat3 d_rdata T+3", d_rdata_w[3], 32'hCAFE_0001);
      chk("lat3 if_gnt T+3", {31'd0, if_gnt_w[3]}, 32'd1);
      chk("lat3 mem_addr T+3", mem_addr_w[3], 32'h200);
      next_cycle();
      if_req = 0;
      repeat (2) next_cycle();
      @(negedge clk);
      chk("lat3 if_rvalid T+6", {31'd0, if_rvalid_w[3]}, 32'd1);
      idle(5);
   endtask

   task automatic test_store();
      d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("store d_gnt", {31'd0, d_gnt_w[1]}, 32'd1);
      chk("store mem_we", {31'd0, mem_we_w[1]}, 32'd1);
      chk("store mem_wdata", mem_wdata_w[1], 32'hDEAD_BEEF);
      chk("store mem_addr", mem_addr_w[1], 32'h40);
      next_cycle();
      d_req = 0; d_we = 0; if_req = 1; if_addr = 32'h44;
      @(negedge clk);
      chk("store next if_gnt T+1", {31'd0, if_gnt_w[1]}, 32'd1);
      chk("store d_rvalid T+1", {31'd0, d_rvalid_w[1]}, 32'd0);
      chk("store mem_wdata idle field", mem_wdata_w[1], 32'd0);
      next_cycle();
      if_req = 0;
      @(negedge clk);
      chk("store d_rvalid T+2", {31'd0, d_rvalid_w[1]}, 32'd0);
      chk("store fetch if_rvalid T+2", {31'd0, if_rvalid_w[1]}, 32'd1);
      idle(5);
   endtask

   task automatic test_arbitration();
      logic [5:0] exp_d;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = 6'b010101;   // bit 0 first: d,i,d,i,d,i
`else
      exp_d = 6'b111111;
`endif
      if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h300;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("arb grant %0d {d,i}", i), {30'd0, d_gnt_w[1], if_gnt_w[1]},
             {30'd0, exp_d[i], ~exp_d[i]});
         next_cycle();
      end
      idle(5);
   endtask

   task automatic test_flush();
      if_req = 1; if_flush = 1; if_addr = 32'h20;
      @(negedge clk);
      chk("flush masks if_gnt", {31'd0, if_gnt_w[1]}, 32'd0);
      chk("flush masks mem_en", {31'd0, mem_en_w[1]}, 32'd0);
      next_cycle();
      if_flush = 0;
      @(negedge clk);
      chk("lat2 if_gnt T", {31'd0, if_gnt_w[2]}, 32'd1);
      next_cycle();
      if_req = 0; if_flush = 1;
      @(negedge clk);
      chk("lat2 busy T+1", {31'd0, busy_w[2]}, 32'd1);
      next_cycle();
      if_flush = 0;
      @(negedge clk);
      chk("lat2 if_rvalid T+2", {31'd0, if_rvalid_w[2]}, 32'd0);
      chk("lat2 busy T+2", {31'd0, busy_w[2]}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("lat2 busy T+3", {31'd0, busy_w[2]}, 32'd0);
      idle(5);
   endtask

   task automatic test_reset_mid();
      if_req = 1; if_addr = 32'h400; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("lat4 if_gnt T", {31'd0, if_gnt_w[4]}, 32'd1);
      next_cycle();
      if_req = 0; d_req = 1; rst = 1;
      #1;
      chk("midrst busy", {31'd0, busy_w[4]}, 32'd0);
      chk("midrst mem_en", {31'd0, mem_en_w[4]}, 32'd0);
      chk("midrst d_gnt", {31'd0, d_gnt_w[4]}, 32'd0);
      chk("midrst if_rdata", if_rdata_w[4], 32'd0);
      next_cycle();
      rst = 0; d_req = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("post-rst rvalid %0d", i), {30'd0, if_rvalid_w[4], d_rvalid_w[4]}, 32'd0);
         next_cycle();
      end
   endtask

   initial begin
      rst = 1; if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      repeat (2) next_cycle();
      test_reset();
      test_fetch();
      test_load_then_fetch();
      test_store();
      test_arbitration();
      test_flush();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
